// File: rtl/rtc_bus_arbiter.sv
// ---------------------------------------------------------------------------
// rtc_bus_arbiter
//
// Shares the single RTC parallel-bus protocol engine between five requesters
// (0 init, 1 RTC reset, 2 user write, 3 chronometer, 4 permanent read).
// A winner is picked in IDLE, its address/data/direction are latched and a
// one-cycle start pulse goes to the engine. The arbiter then waits in WAIT
// for the engine's completion (or a timeout), pulses done to the owner and
// spends GAP_CYCLES cycles of bus turnaround in GAP before arbitrating again.
// A requester holding lock keeps ownership across consecutive transactions.
// Read starvation is bounded: after STARVE_LIMIT non-read grants while read
// is pending, read is forced through (init still has top priority).
//
// Ports:
//   clk          system clock
//   Reset        synchronous, active-high reset
//   req[4:0]     request per requester
//   rw_in[4:0]   per requester direction, 1 = read
//   lock[4:0]    per requester bus lock
//   addr_in      byte i = address of requester i
//   wdata_in     byte i = write data of requester i
//   gnt          one-hot current owner
//   done         one-cycle completion pulse to the owner
//   rdata        read data, valid while done pulses
//   err_timeout  one-cycle pulse on abort
//   busy         high whenever the arbiter is not idle
//   proto_start  one-cycle start pulse to the engine
//   proto_addr   latched address
//   proto_wdata  latched write data
//   proto_rw     latched direction
//   proto_done   engine completion pulse
//   proto_rdata  engine read data, valid while proto_done is high
// All outputs are registered.
// ---------------------------------------------------------------------------
module rtc_bus_arbiter #(
    parameter int TIMEOUT      = 1023,
    parameter int GAP_CYCLES   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic [4:0]  req,
    input  logic [4:0]  rw_in,
    input  logic [4:0]  lock,
    input  logic [39:0] addr_in,
    input  logic [39:0] wdata_in,
    output logic [4:0]  gnt,
    output logic [4:0]  done,
    output logic [7:0]  rdata,
    output logic        err_timeout,
    output logic        busy,
    output logic        proto_start,
    output logic [7:0]  proto_addr,
    output logic [7:0]  proto_wdata,
    output logic        proto_rw,
    input  logic        proto_done,
    input  logic [7:0]  proto_rdata
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [9:0]    TO_LAST    = 10'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t         r_state;
    logic [4:0]     r_gnt;
    logic [4:0]     r_done;
    logic [7:0]     r_rdata;
    logic           r_err;
    logic           r_busy;
    logic           r_start;
    logic [7:0]     r_addr;
    logic [7:0]     r_wdata;
    logic           r_rw;
    logic [9:0]     r_tcnt;
    logic [SW-1:0]  r_starve;
    logic [GW-1:0]  r_gap_cnt;
    logic [2:0]     r_owner;
    logic           r_lock_valid;

    logic           w_lock_hold;
    logic           w_win_valid;
    logic [2:0]     w_win_idx;
    logic [5:0]     w_byte_base;

    // Index to one-hot grant/done vector.
    function automatic logic [4:0] f_onehot(input logic [2:0] idx);
        f_onehot = 5'b00001 << idx;
    endfunction

    // Winner selection: locked owner, then init, then forced read, then lowest index.
    always_comb begin
        w_lock_hold = r_lock_valid && req[r_owner] && lock[r_owner];
        w_win_valid = 1'b0;
        w_win_idx   = 3'd0;
        if (w_lock_hold) begin
            w_win_valid = 1'b1;
            w_win_idx   = r_owner;
        end else if (req[0]) begin
            w_win_valid = 1'b1;
            w_win_idx   = 3'd0;
        end else if (req[4] && (r_starve == STARVE_MAX)) begin
            w_win_valid = 1'b1;
            w_win_idx   = 3'd4;
        end else if (req[1]) begin
            w_win_valid = 1'b1;
            w_win_idx   = 3'd1;
        end else if (req[2]) begin
            w_win_valid = 1'b1;
            w_win_idx   = 3'd2;
        end else if (req[3]) begin
            w_win_valid = 1'b1;
            w_win_idx   = 3'd3;
        end else if (req[4]) begin
            w_win_valid = 1'b1;
            w_win_idx   = 3'd4;
        end else begin
            w_win_valid = 1'b0;
            w_win_idx   = 3'd0;
        end
        w_byte_base = {w_win_idx, 3'b000};
    end

    // Arbitration FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state      <= ST_IDLE;
            r_gnt        <= 5'd0;
            r_done       <= 5'd0;
            r_rdata      <= 8'd0;
            r_err        <= 1'b0;
            r_busy       <= 1'b0;
            r_start      <= 1'b0;
            r_addr       <= 8'd0;
            r_wdata      <= 8'd0;
            r_rw         <= 1'b0;
            r_tcnt       <= 10'd0;
            r_starve     <= '0;
            r_gap_cnt    <= '0;
            r_owner      <= 3'd0;
            r_lock_valid <= 1'b0;
        end else begin
            // Pulse outputs default low and are raised only on their event.
            r_start <= 1'b0;
            r_done  <= 5'd0;
            r_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_win_valid) begin
                        r_gnt   <= f_onehot(w_win_idx);
                        r_owner <= w_win_idx;
                        r_addr  <= addr_in[w_byte_base +: 8];
                        r_wdata <= wdata_in[w_byte_base +: 8];
                        r_rw    <= rw_in[w_win_idx];
                        r_start <= 1'b1;
                        r_tcnt  <= 10'd0;
                        r_busy  <= 1'b1;
                        r_state <= ST_WAIT;
                        // A grant to anyone else ends any previous lock.
                        if (!w_lock_hold) begin
                            r_lock_valid <= 1'b0;
                        end
                        // Read-starvation bookkeeping; init grants with read
                        // pending leave the count untouched.
                        if (w_win_idx == 3'd4 || !req[4]) begin
                            r_starve <= '0;
                        end else if (w_win_idx != 3'd0 && r_starve != STARVE_MAX) begin
                            r_starve <= r_starve + SW'(1);
                        end
                    end else begin
                        r_gnt        <= 5'd0;
                        r_lock_valid <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    r_gap_cnt <= '0;
                    if (proto_done) begin
                        // Completion beats a coincident timeout.
                        if (r_rw) begin
                            r_rdata <= proto_rdata;
                        end
                        r_done  <= f_onehot(r_owner);
                        r_state <= ST_GAP;
                        if (lock[r_owner]) begin
                            r_lock_valid <= 1'b1;
                        end else begin
                            r_lock_valid <= 1'b0;
                            r_gnt        <= 5'd0;
                        end
                    end else if (r_tcnt == TO_LAST) begin
                        r_err        <= 1'b1;
                        r_done       <= f_onehot(r_owner);
                        r_rdata      <= 8'hFF;
                        r_lock_valid <= 1'b0;
                        r_gnt        <= 5'd0;
                        r_state      <= ST_GAP;
                    end else begin
                        r_tcnt <= r_tcnt + 10'd1;
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GW'(1);
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_busy       <= 1'b0;
                    r_gnt        <= 5'd0;
                    r_lock_valid <= 1'b0;
                end
            endcase
        end
    end

    assign gnt         = r_gnt;
    assign done        = r_done;
    assign rdata       = r_rdata;
    assign err_timeout = r_err;
    assign busy        = r_busy;
    assign proto_start = r_start;
    assign proto_addr  = r_addr;
    assign proto_wdata = r_wdata;
    assign proto_rw    = r_rw;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Scoreboard bench for rtc_bus_arbiter: expected engine-start and done events
// are queued by the stimulus; a monitor pops and compares them whenever the
// DUT raises proto_start or done. A small engine model answers starts.
module tb_rtc_bus_arbiter;

    logic        clk = 1'b0;
    logic        Reset;
    logic [4:0]  req, rw_in, lock;
    logic [39:0] addr_in, wdata_in;
    logic [4:0]  gnt, done;
    logic [7:0]  rdata;
    logic        err_timeout, busy, proto_start, proto_rw;
    logic [7:0]  proto_addr, proto_wdata;
    logic        proto_done;
    logic [7:0]  proto_rdata;

    int n_pass  = 0;
    int n_total = 0;

    logic [21:0] q_start[$];
    logic [13:0] q_done[$];
    logic [21:0] mon_s;
    logic [13:0] mon_d;

    logic        eng_mute;
    int          eng_delay;
    logic [7:0]  eng_rdata;

    rtc_bus_arbiter dut (
        .clk(clk), .Reset(Reset), .req(req), .rw_in(rw_in), .lock(lock),
        .addr_in(addr_in), .wdata_in(wdata_in), .gnt(gnt), .done(done),
        .rdata(rdata), .err_timeout(err_timeout), .busy(busy),
        .proto_start(proto_start), .proto_addr(proto_addr),
        .proto_wdata(proto_wdata), .proto_rw(proto_rw),
        .proto_done(proto_done), .proto_rdata(proto_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    task automatic push_start(input int i);
        q_start.push_back({5'b00001 << i, addr_in[i*8 +: 8], wdata_in[i*8 +: 8], rw_in[i]});
    endtask

    task automatic push_done(input logic [4:0] d, input logic [7:0] rd, input logic err);
        q_done.push_back({d, rd, err});
    endtask

    task automatic wait_start(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (proto_start !== 1'b1 && cyc < 2000);
        check("start_seen", 64'(proto_start), 64'(1));
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (done === 5'd0 && cyc < 1200);
        check("done_seen", 64'(done != 5'd0), 64'(1));
    endtask

    // Protocol-engine model: answers each start after eng_delay cycles.
    initial begin
        proto_done  = 1'b0;
        proto_rdata = 8'h00;
        forever begin
            @(negedge clk);
            proto_done = 1'b0;
            if (proto_start === 1'b1 && !eng_mute) begin
                repeat (eng_delay - 1) @(negedge clk);
                proto_done  = 1'b1;
                proto_rdata = eng_rdata;
            end
        end
    end

    // Monitor: compare every start/done event against the scoreboard.
    always @(negedge clk) begin
        if (proto_start === 1'b1) begin
            if (q_start.size() == 0) begin
                check("unexpected_start", 64'(gnt), 64'(0));
            end else begin
                mon_s = q_start.pop_front();
                check("start_gnt_addr_wdata_rw",
                      64'({gnt, proto_addr, proto_wdata, proto_rw}), 64'(mon_s));
            end
        end
        if (done !== 5'd0 && done !== 5'bxxxxx) begin
            if (q_done.size() == 0) begin
                check("unexpected_done", 64'(done), 64'(0));
            end else begin
                mon_d = q_done.pop_front();
                check("done_rdata_err", 64'({done, rdata, err_timeout}), 64'(mon_d));
            end
        end
    end

    initial begin
        int c;
        Reset     = 1'b1;
        req       = 5'b00000;
        rw_in     = 5'b10000;
        lock      = 5'b00000;
        addr_in   = {8'h44, 8'h33, 8'h21, 8'h11, 8'h01};
        wdata_in  = {8'h4D, 8'h3C, 8'h45, 8'h1A, 8'h0F};
        eng_mute  = 1'b0;
        eng_delay = 5;
        eng_rdata = 8'h37;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              64'({gnt, done, rdata, err_timeout, busy, proto_start, proto_addr, proto_wdata, proto_rw}),
              64'(0));
        Reset = 1'b0;

        // Single write from requester 2.
        push_start(2);
        push_done(5'b00100, 8'h00, 1'b0);
        req = 5'b00100;
        wait_start(c);
        check("t1_start_latency", 64'(c), 64'(1));
        check("t1_addr_wdata", 64'({proto_addr, proto_wdata}), 64'(16'h2145));
        wait_done(c);
        req = 5'b00000;
        check("t1_done_latency", 64'(c), 64'(5));
        check("t1_gap_gnt_busy", 64'({gnt, busy}), 64'({5'b00000, 1'b1}));
        @(negedge clk);
        check("t1_busy_gap2", 64'(busy), 64'(1));
        @(negedge clk);
        check("t1_idle", 64'(busy), 64'(0));

        // Priority and read starvation: grants 1,2,2,2 then forced read.
        eng_delay = 3;
        push_start(1); push_done(5'b00010, 8'h00, 1'b0);
        for (int k = 0; k < 3; k++) begin
            push_start(2); push_done(5'b00100, 8'h00, 1'b0);
        end
        push_start(4); push_done(5'b10000, 8'h37, 1'b0);
        req = 5'b11110;
        for (int k = 0; k < 5; k++) begin
            wait_done(c);
            if (k == 0) req[1] = 1'b0;
            if (k == 4) req = 5'b00000;
        end
        check("t2_read_rdata", 64'(rdata), 64'(8'h37));
        repeat (2) @(negedge clk);

        // Lock burst of 8 writes from requester 2 with requester 3 waiting,
        // then requester 3 locked while init arrives mid-transaction.
        for (int k = 0; k < 8; k++) begin
            push_start(2); push_done(5'b00100, 8'h37, 1'b0);
        end
        push_start(3); push_done(5'b01000, 8'h37, 1'b0);
        push_start(3); push_done(5'b01000, 8'h37, 1'b0);
        push_start(0); push_done(5'b00001, 8'h37, 1'b0);
        lock = 5'b00100;
        req  = 5'b01100;
        for (int k = 0; k < 8; k++) begin
            wait_done(c);
            check("t3_gnt_held", 64'(gnt), 64'(5'b00100));
            if (k == 7) begin
                req[2] = 1'b0;
                lock   = 5'b01000;
            end
        end
        eng_delay = 6;
        wait_start(c);
        repeat (2) @(negedge clk);
        req[0] = 1'b1;
        check("t4_owner_mid_wait", 64'(gnt), 64'(5'b01000));
        wait_done(c);
        check("t4_gnt_locked", 64'(gnt), 64'(5'b01000));
        wait_start(c);
        check("t4_regrant_owner", 64'(gnt), 64'(5'b01000));
        wait_done(c);
        lock = 5'b00000;
        wait_start(c);
        check("t4_init_wins", 64'(gnt), 64'(5'b00001));
        wait_done(c);
        req = 5'b00000;
        repeat (2) @(negedge clk);

        // Timeout with a locked owner, then a normal transaction.
        eng_mute = 1'b1;
        push_start(2); push_done(5'b00100, 8'hFF, 1'b1);
        lock = 5'b00100;
        req  = 5'b00100;
        wait_start(c);
        wait_done(c);
        check("t5_timeout_cycles", 64'(c), 64'(1023));
        check("t5_err_pulse", 64'(err_timeout), 64'(1));
        check("t5_lock_cleared", 64'(gnt), 64'(5'b00000));
        req      = 5'b00000;
        lock     = 5'b00000;
        eng_mute = 1'b0;
        @(negedge clk);
        check("t5_err_one_cycle", 64'(err_timeout), 64'(0));
        @(negedge clk);
        push_start(3); push_done(5'b01000, 8'hFF, 1'b0);
        req = 5'b01000;
        wait_start(c);
        wait_done(c);
        req = 5'b00000;
        repeat (2) @(negedge clk);

        // Reset in the middle of WAIT; the late proto_done must be ignored.
        eng_delay = 8;
        push_start(1);
        req = 5'b00010;
        wait_start(c);
        repeat (2) @(negedge clk);
        Reset = 1'b1;
        req   = 5'b00000;
        @(negedge clk);
        check("t6_reset_outputs",
              64'({gnt, done, rdata, err_timeout, busy, proto_start, proto_addr, proto_wdata, proto_rw}),
              64'(0));
        Reset = 1'b0;
        repeat (12) @(negedge clk);
        check("t6_idle_after_late_done", 64'({gnt, busy, rdata}), 64'(0));

        check("start_queue_empty", 64'(q_start.size()), 64'(0));
        check("done_queue_empty", 64'(q_done.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
